abba_stream_scheduler: RTL
==========================

Name: abba_stream_scheduler

Overview:
Time-multiplexes one "abba" string-recognizer step function across NREQ independent symbol streams. Each cycle, a round-robin arbiter grants at most one requesting stream. The block applies the step function to that stream's saved 2-bit context, writes the next state back, and reports the Mealy output one cycle later. It sits between the symbol sources and the consumers of match events, and it is the only owner of the recognizer contexts.

Parameters:
NREQ, 4, number of streams (2..16)
IDW, 2, stream-id width, equal to clog2(NREQ)
CW, 8, width of each per-stream saturating match counter

Ports:
clock  input  1  system clock, rising edge active
reset_n  input  1  asynchronous, active-low reset
req  input  NREQ  req[i]=1: stream i presents a symbol this cycle
sym  input  2*NREQ  symbol of stream i is sym[2i+1:2i] = {x1,x2}
clr  input  NREQ  clr[i]=1: force context of stream i to 00 at next edge
gnt  output  NREQ  one-hot grant, combinational; req[i]&gnt[i] means the symbol is consumed
out_valid  output  1  registered: a symbol was processed last cycle
out_id  output  IDW  registered: stream id of that symbol
out_z  output  1  registered: recognizer output for that symbol
out_state  output  2  registered: next state written back for that stream
rd_id  input  IDW  counter read select
rd_count  output  CW  combinational: match counter of stream rd_id

Behaviour:
- Step function, with state s={s1,s2} and input x={x1,x2}:
  - ns1 = s2&~x1&x2
  - ns2 = ~s1&s2&~x1 | ~s1&~x2 | s2&~x2
  - z = s1&~s2&~x1&~x2
  - Symbols: a=00, b=01. From context 00, the sequence a,b,b,a gives states 01, 11, 10, 00 and z=1 on the final a.
- Storage: ctx[NREQ] (2 bits each), rr pointer (IDW bits), cnt[NREQ] (CW bits).
- Reset (reset_n=0, asynchronous):
  - all ctx=00, rr=0, all cnt=0
  - out_valid=0, out_id=0, out_z=0, out_state=00
  - gnt forced to 0 while reset_n is low
  - asserting reset mid-stream discards any symbol presented in that cycle.
- Eligibility: eligible[i] = req[i] & ~clr[i]. Clear masks the grant; a symbol presented together with its own clear is not consumed, and the source must hold it.
- Arbitration, combinational, round-robin: scan i = rr, rr+1, ..., wrapping modulo NREQ. The first eligible i gets gnt[i]=1. No eligible stream gives gnt=0. gnt is never multi-hot.
- On the edge following a grant to stream w:
  - ctx[w] <= ns(ctx[w], sym_w)
  - rr <= (w+1) mod NREQ
  - out_valid <= 1, out_id <= w, out_z <= z(ctx[w], sym_w), out_state <= ns
  - if z=1: cnt[w] <= cnt[w]+1, saturating at 2^CW-1 (no wrap).
- On an edge with no grant: out_valid <= 0; out_id, out_z and out_state hold; rr holds.
- Clear: on each edge, ctx[i] <= 00 for every i with clr[i]=1. Clear does not reset cnt[i]. Multiple clears in one cycle are allowed.
- Latency: symbol consumed in cycle t; result visible on out_* during cycle t+1. Back-to-back grants to the same stream (NREQ=1, or it is the only requester) see the updated context with no bubble, so throughput is 1 symbol/cycle.
- Fairness: a stream that holds req continuously is granted within NREQ cycles.
- rd_count reflects cnt[rd_id] as of the last edge; a read in the same cycle as an increment returns the old value.
- Contexts of non-granted streams are never modified except by clr.

Test Plan:
- Reset: hold reset_n=0 with all req=1 -> gnt=0, out_valid=0, rd_count=0 for all ids; release -> first grant is stream 0.
- Single stream: stream 0 sends 00,01,01,00 on consecutive cycles with the others idle -> out_z = 0,0,0,1 in cycles t+1..t+4; out_state = 01,11,10,00; cnt[0]=1.
- Interleaving: streams 1 and 2 both send a,b,b,a with req held continuously -> grants alternate 1,2,1,2,...; each stream reports out_z=1 on its 4th symbol; cnt[1]=cnt[2]=1; cnt[0]=cnt[3]=0.
- Fairness and wrap: all four req held for 8 cycles starting with rr=2 -> grant order 2,3,0,1,2,3,0,1.
- Clear collision: stream 3 at context 10 asserts clr[3] and req[3] with sym=00 in the same cycle -> gnt[3]=0, no match, ctx[3]=00 next cycle; the held symbol is then granted with out_z=0 and out_state=01.
- Saturation with CW=2: stream 0 completes abba 5 times -> rd_count goes 1,2,3,3,3.

Source files
------------

// File: rtl/abba_stream_scheduler.sv
// Round-robin time-multiplexed "abba" recognizer over NREQ symbol streams; result is registered 1 cycle after grant.
// Backpressure: gnt is the only acceptance signal, a stream whose symbol is not granted (or is being cleared) must hold it.
module abba_stream_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CW   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] sym,
  input  logic [NREQ-1:0]   clr,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  output logic [IDW-1:0]    out_id,
  output logic              out_z,
  output logic [1:0]        out_state,
  input  logic [IDW-1:0]    rd_id,
  output logic [CW-1:0]     rd_count
);

  logic [1:0]      ctx [NREQ];
  logic [CW-1:0]   cnt [NREQ];
  logic [IDW-1:0]  rr;
  logic [NREQ-1:0] eligible;
  logic            grant_any;
  logic            grant_ok;
  logic [IDW-1:0]  win_id;
  logic [1:0]      cur_s;
  logic [1:0]      cur_x;
  logic [1:0]      nxt_s;
  logic            cur_z;

  // Stream index arithmetic modulo NREQ, valid for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] base, input int offs);
    int t;
    t = int'(base) + offs;
    if (t >= NREQ) t = t - NREQ;
    return t[IDW-1:0];
  endfunction

  assign eligible = req & ~clr;

  always_comb begin
    grant_any = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && eligible[wrap_inc(rr, k)]) begin
        grant_any = 1'b1;
        win_id    = wrap_inc(rr, k);
      end
    end
  end

  assign grant_ok = grant_any & reset_n;

  always_comb begin
    gnt = '0;
    if (grant_ok) gnt[win_id] = 1'b1;
  end

  // Shared step function, evaluated only for the granted stream.
  assign cur_s    = ctx[win_id];
  assign cur_x    = sym[{win_id, 1'b0} +: 2];
  assign nxt_s[1] = cur_s[0] & ~cur_x[1] & cur_x[0];
  assign nxt_s[0] = (~cur_s[1] & cur_s[0] & ~cur_x[1]) | (~cur_s[1] & ~cur_x[0]) | (cur_s[0] & ~cur_x[0]);
  assign cur_z    = cur_s[1] & ~cur_s[0] & ~cur_x[1] & ~cur_x[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) begin
        ctx[i] <= 2'b00;
        cnt[i] <= '0;
      end
      rr        <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_z     <= 1'b0;
      out_state <= 2'b00;
    end else begin
      // A cleared stream is never eligible, so clear and write-back cannot target the same context.
      for (int i = 0; i < NREQ; i++) begin
        if (clr[i]) ctx[i] <= 2'b00;
      end
      out_valid <= grant_ok;
      if (grant_ok) begin
        ctx[win_id] <= nxt_s;
        rr          <= wrap_inc(win_id, 1);
        out_id      <= win_id;
        out_z       <= cur_z;
        out_state   <= nxt_s;
        if (cur_z && cnt[win_id] != '1) cnt[win_id] <= cnt[win_id] + 1'b1;
      end
    end
  end

  assign rd_count = (int'(rd_id) < NREQ) ? cnt[rd_id] : '0;

endmodule
